seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `x` stream consumed by our Moore sequence detectors. It takes a PAT_W-bit pattern, a repeat count and an overlap length, and shifts the pattern out MSB-first at one bit per clock. When the overlap length is non-zero, each repetition after the first omits the leading `ovl` bits, so the stream contains back-to-back overlapping occurrences. All outputs are registered (Moore), which makes the block usable as a synthesizable stimulus source in front of `moore_overlapping` and its siblings.

## Interface
- `PAT_W`, 4, pattern width in bits; must be ≥2 and a power of two.
- `CNT_W`, 4, width of the repeat-count input.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin transmission; sampled only in IDLE.
- `pattern`  in  PAT_W  pattern to send; bit PAT_W-1 goes out first.
- `reps`  in  CNT_W  number of pattern occurrences to emit (0..2^CNT_W-1).
- `ovl`  in  $clog2(PAT_W)  overlap length (0..PAT_W-1) between consecutive occurrences.
- `x`  out  1  serial data bit; 0 whenever `x_valid`=0.
- `x_valid`  out  1  high while `x` carries a pattern bit.
- `busy`  out  1  high from the cycle after start is accepted until transmission ends.
- `done`  out  1  one-cycle pulse after the last bit is sent, or after a zero-rep request.

## Operation
- Reset (asynchronous, `rst_n`=0): state goes to IDLE; `x`, `x_valid`, `busy` and `done` all go to 0; latched pattern and counters are cleared. Reset asserted mid-stream aborts the transfer immediately, with no `done` pulse.
- FSM states: IDLE, FIRST, REPEAT, DONE.
- IDLE: if `start`=1 at a rising edge, latch `pattern`, `reps` and `ovl`.
  - If `reps`=0, go to DONE.
  - Otherwise go to FIRST with the bit index at PAT_W-1 and the remaining-reps counter at `reps`-1.
- FIRST: emit `pattern[idx]` and decrement `idx`.
  - After bit 0, go to DONE if remaining reps = 0.
  - Otherwise go to REPEAT with `idx` = PAT_W-1-ovl and remaining reps decremented.
- REPEAT: emit bits `idx` down to 0, i.e. PAT_W-ovl bits per occurrence.
  - At bit 0, reload `idx` = PAT_W-1-ovl and decrement remaining reps if reps remain; otherwise go to DONE.
- DONE: for exactly one cycle, `done`=1, `busy`=0 and `x_valid`=0; then return to IDLE.
- Total emitted bits: N = PAT_W + (reps-1)·(PAT_W-ovl) for reps ≥ 1, and 0 for reps = 0.
- Inputs change only the latched copy. Changes to `pattern`, `reps` or `ovl` while busy have no effect.
- `start` in FIRST, REPEAT or DONE is ignored; it is not queued.
- The block does not check that `ovl` is consistent with the pattern. The caller is responsible for choosing `ovl` so that the suffix equals the prefix.
- Counters do not wrap: the maximum `reps` of 2^CNT_W-1 is emitted exactly.

## Timing
- Let E0 be the edge at which `start` is accepted.
- After E0: `busy`=1, `x_valid`=1, `x`=pattern[PAT_W-1].
- After edge E(k), `x` holds stream bit k, for k = 0..N-1. Each bit is stable for a full cycle, so a downstream detector samples it at edge E(k+1).
- After E(N): `x_valid`=0, `x`=0, `busy`=0, `done`=1.
- After E(N+1): `done`=0 and the state is IDLE. The earliest accepted next `start` is at E(N+2), giving one idle cycle between transfers.
- For `reps`=0: after E0, `done`=1 with `busy`=0 and `x_valid`=0; after E1, `done`=0.
- Latency from start to first bit: 1 cycle. Throughput: 1 bit per cycle, with no gaps inside a transfer.

## Test plan
- Reset: hold `rst_n`=0 for 1 cycle, then release → `x`, `x_valid`, `busy` and `done` are all 0. Assert `rst_n`=0 at bit 3 of a transfer → all outputs are 0 immediately, with no `done` pulse.
- Non-overlapping: `pattern`=4'b1010, `reps`=2, `ovl`=0 → 8 bits 1,0,1,0,1,0,1,0, then a single-cycle `done` one cycle after the last bit.
- Overlapping: `pattern`=4'b1101, `reps`=3, `ovl`=1 → 10 bits 1101101101. Feeding these into a 1101 overlapping Moore detector must produce exactly 3 `z` pulses.
- Maximum overlap: `pattern`=4'b1111, `reps`=4, `ovl`=3 → 7 consecutive 1s with `x_valid` high for exactly 7 cycles.
- Zero reps: `reps`=0 with `start` pulsed → `x_valid` never rises, `busy` stays 0, and `done` pulses one cycle after the start edge.
- Start while busy: pulse `start` again with a different pattern mid-stream → the original stream completes unchanged, only one `done` is produced, and the second request is dropped. A `start` held high through DONE is accepted at E(N+2).

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated
// `reps` times, with later occurrences skipping their leading `ovl` bits.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [CNT_W-1:0]           reps,
  input  logic [$clog2(PAT_W)-1:0]   ovl,
  output logic                       x,
  output logic                       x_valid,
  output logic                       busy,
  output logic                       done
);

  // state  | meaning
  // IDLE   | waiting for start
  // FIRST  | sending the first, full-length occurrence
  // REPEAT | sending trimmed occurrences (PAT_W-ovl bits each)
  // DONE   | one-cycle done pulse, then back to IDLE
  localparam int IW = $clog2(PAT_W);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IW-1:0]    IDX_MAX = IW'(PAT_W - 1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IW-1:0]    ovl_q, ovl_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed one cycle ahead so that every output is a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d = pattern;
          ovl_d = ovl;
          if (reps == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FIRST;
            idx_d   = IDX_MAX;
            rem_d   = reps - CNT_ONE;
            x_d     = pattern[PAT_W-1];
            xv_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_FIRST, S_REPEAT: begin
        if (idx_q != '0) begin
          idx_d  = idx_q - IDX_ONE;
          x_d    = pat_q[idx_d];
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // Next occurrence starts past the overlapped prefix.
          state_d = S_REPEAT;
          idx_d   = IDX_MAX - ovl_q;
          rem_d   = rem_q - CNT_ONE;
          x_d     = pat_q[idx_d];
          xv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: queue-based stream model checked every cycle,
// plus literal expectations on captured streams and done pulses.
module tb_seq_pattern_tx;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [3:0] reps = '0;
  logic [1:0] ovl = '0;
  logic       x, x_valid, busy, done;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .reps(reps),
    .ovl(ovl), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: on an accepted start, expand the whole bit stream into a queue.
  typedef enum {M_IDLE, M_SEND, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  bit    stream[$];
  int    pos = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: if (start) begin
          stream.delete();
          for (int occ = 0; occ < int'(reps); occ++) begin
            int first;
            first = (occ == 0) ? PAT_W - 1 : PAT_W - 1 - int'(ovl);
            for (int b = first; b >= 0; b--) stream.push_back(pattern[b]);
          end
          pos  = 0;
          mode = (stream.size() == 0) ? M_DONE : M_SEND;
        end
        M_SEND: begin
          pos++;
          if (pos == stream.size()) mode = M_DONE;
        end
        M_DONE: mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
  end

  bit cap[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    logic ex, exv, eb, ed;
    ex = 0; exv = 0; eb = 0; ed = 0;
    if (mode == M_SEND) begin
      ex = stream[pos]; exv = 1; eb = 1;
    end else if (mode == M_DONE) begin
      ed = 1;
    end
    chk("x", x, ex);
    chk("x_valid", x_valid, exv);
    chk("busy", busy, eb);
    chk("done", done, ed);
    if (x_valid) cap.push_back(x);
    if (done) done_cnt++;
  end

  task automatic send_start(input logic [3:0] p, input logic [3:0] r, input logic [1:0] o);
    pattern = p; reps = r; ovl = o; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cap.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  function automatic logic [31:0] cap_val();
    logic [31:0] v;
    v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  function automatic int count_1101();
    int n;
    n = 0;
    for (int i = 0; i + 3 < cap.size(); i++)
      if (cap[i] && cap[i+1] && !cap[i+2] && cap[i+3]) n++;
    return n;
  endfunction

  initial begin
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("rst_x", x, 0);
    chk("rst_xv", x_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #2;

    // Non-overlapping
    send_start(4'b1010, 4'd2, 2'd0);
    wait_done("nonovl");
    chk("nonovl_len", cap.size(), 8);
    chk("nonovl_bits", cap_val(), 32'b10101010);
    chk("nonovl_done", done_cnt, 1);
    @(posedge clk); #2;

    // Overlapping
    send_start(4'b1101, 4'd3, 2'd1);
    wait_done("ovl");
    chk("ovl_len", cap.size(), 10);
    chk("ovl_bits", cap_val(), 32'b1101101101);
    chk("ovl_z", count_1101(), 3);
    @(posedge clk); #2;

    // Maximum overlap
    send_start(4'b1111, 4'd4, 2'd3);
    wait_done("maxovl");
    chk("maxovl_len", cap.size(), 7);
    chk("maxovl_bits", cap_val(), 32'b1111111);
    @(posedge clk); #2;

    // Zero reps
    send_start(4'b1011, 4'd0, 2'd0);
    #3;
    chk("zero_done_now", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #2;
    chk("zero_done_clear", done, 0);
    chk("zero_len", cap.size(), 0);
    chk("zero_done_cnt", done_cnt, 1);
    @(posedge clk); #2;

    // Maximum reps
    send_start(4'b1001, 4'd15, 2'd0);
    wait_done("maxreps");
    chk("maxreps_len", cap.size(), 60);
    @(posedge clk); #2;

    // Start while busy is dropped
    send_start(4'b1010, 4'd2, 2'd0);
    repeat (3) @(posedge clk);
    #2;
    pattern = 4'b0110; reps = 4'd5; ovl = 2'd2; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("busy_start");
    repeat (3) @(posedge clk);
    #2;
    chk("busy_len", cap.size(), 8);
    chk("busy_bits", cap_val(), 32'b10101010);
    chk("busy_done_cnt", done_cnt, 1);

    // Start held through DONE is accepted at E(N+2)
    send_start(4'b1010, 4'd1, 2'd0);
    pattern = 4'b0011; reps = 4'd1; ovl = 2'd0; start = 1'b1;
    wait_done("held");
    @(negedge clk); #1;
    chk("held_gap_xv", x_valid, 0);
    @(negedge clk); #1;
    chk("held_accept_xv", x_valid, 1);
    chk("held_accept_busy", busy, 1);
    chk("held_accept_x", x, 0);
    start = 1'b0;
    cap.delete();
    done_cnt = 0;
    cap.push_back(x);
    wait_done("held2");
    chk("held2_bits", cap_val(), 32'b0011);
    @(posedge clk); #2;

    // Reset mid-stream at bit 3
    send_start(4'b1101, 4'd2, 2'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_xv", x_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_x", x, 0);
    chk("midrst_xv", x_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("midrst_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
